// File: rtl/uart_rx_core_if.sv
// -----------------------------------------------------------------------------
// uart_rx_core_if
//   Byte stream from the UART receiver to its consumer.
//
//   Handshake: a byte moves when rx_valid && rx_ready are both 1 at a clk edge.
//   The source holds rx_data stable while rx_valid=1 and the byte has not been
//   taken. The only exception is an overrun, where the source replaces the
//   byte. rx_ready may be driven independently of rx_valid.
//
//   Signals
//     rx_data   source -> sink   received byte
//     rx_valid  source -> sink   rx_data holds an unconsumed byte
//     rx_ready  sink   -> source consumer accepts the byte
//   Modports
//     master : the receiver (drives rx_data / rx_valid)
//     slave  : the consumer (drives rx_ready)
// -----------------------------------------------------------------------------
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   UART serial receiver for 8N1 / 8E1 / 8O1 frames with OVERSAMPLE-times
//   oversampling. Received bytes are delivered on rx_if, which carries a
//   valid/ready handshake. Frame errors are reported as single-cycle pulses,
//   and these pulses line up with the publish of the byte.
//
//   Ports
//     clk_i                 system clock
//     rst_n_i               synchronous active-low reset
//     rx_i                  asynchronous serial line, idle high
//     baud_div_i            clk cycles per oversample tick, 0 disables receiver
//     parity_en_i           parity bit follows the data bits
//     parity_odd_i          1 = odd parity, 0 = even
//     rx_if                 byte output (master modport)
//     stop_bit_check_error  1-cycle pulse, stop bit sampled 0
//     parity_check_error    1-cycle pulse, parity mismatch
//     overrun_o             1-cycle pulse, unconsumed byte overwritten
//     busy_o                frame reception in progress
//     state_o               debug view of the FSM state
//                           0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rx_i,
  input  logic [16:0]           baud_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  uart_rx_core_if.master        rx_if,
  output logic                  stop_bit_check_error,
  output logic                  parity_check_error,
  output logic                  overrun_o,
  output logic                  busy_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int OS_W  = $clog2(OVERSAMPLE + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  OS_FULL   = OS_W'(OVERSAMPLE);
  localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  state_t                 state;
  logic [16:0]            tick_cnt;
  logic                   tick;
  logic [OS_W-1:0]        os_cnt;
  logic [OS_W-1:0]        os_next;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_en_q;
  logic                   par_odd_q;
  logic                   par_err_q;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign os_next = os_cnt + 1'b1;
  assign busy_o  = (state != IDLE);
  assign state_o = state;

  // The >= compare means a divisor that shrinks mid-frame still wraps the
  // counter, so the FSM never waits forever on an unreachable count.
  assign tick = (state != IDLE) && (baud_div_i != 17'd0) &&
                (tick_cnt >= baud_div_i - 17'd1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  // Held at zero in IDLE so the first tick lands baud_div cycles after the
  // start edge, which keeps sampling phase-aligned to the frame.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || state == IDLE || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 17'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state                <= IDLE;
      rx_prev              <= 1'b1;
      os_cnt               <= '0;
      bit_cnt              <= '0;
      shift_q              <= '0;
      par_en_q             <= 1'b0;
      par_odd_q            <= 1'b0;
      par_err_q            <= 1'b0;
      rx_if.rx_data        <= '0;
      rx_if.rx_valid       <= 1'b0;
      stop_bit_check_error <= 1'b0;
      parity_check_error   <= 1'b0;
      overrun_o            <= 1'b0;
    end else begin
      rx_prev              <= rx_s;
      stop_bit_check_error <= 1'b0;
      parity_check_error   <= 1'b0;
      overrun_o            <= 1'b0;

      if (rx_if.rx_valid && rx_if.rx_ready) begin
        rx_if.rx_valid <= 1'b0;
      end

      if (baud_div_i == 17'd0) begin
        state  <= IDLE;
        os_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            // Edge, not level: a line stuck low after a break stays idle.
            if (rx_prev && !rx_s) begin
              state  <= START;
              os_cnt <= '0;
            end
          end
          START: begin
            if (tick) begin
              if (os_next == OS_HALF) begin
                os_cnt <= '0;
                if (rx_s) begin
                  state <= IDLE;
                end else begin
                  state     <= DATA;
                  bit_cnt   <= '0;
                  par_en_q  <= parity_en_i;
                  par_odd_q <= parity_odd_i;
                  par_err_q <= 1'b0;
                end
              end else begin
                os_cnt <= os_next;
              end
            end
          end
          DATA: begin
            if (tick) begin
              if (os_next == OS_FULL) begin
                os_cnt  <= '0;
                shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == BITS_LAST) begin
                  state <= par_en_q ? PARITY : STOP;
                end
              end else begin
                os_cnt <= os_next;
              end
            end
          end
          PARITY: begin
            if (tick) begin
              if (os_next == OS_FULL) begin
                os_cnt    <= '0;
                par_err_q <= ((^shift_q) ^ rx_s) != par_odd_q;
                state     <= STOP;
              end else begin
                os_cnt <= os_next;
              end
            end
          end
          STOP: begin
            if (tick) begin
              if (os_next == OS_FULL) begin
                os_cnt               <= '0;
                state                <= IDLE;
                // Publish overrides the transfer-clear above, so a byte
                // taken this cycle is replaced rather than flagged.
                rx_if.rx_data        <= shift_q;
                rx_if.rx_valid       <= 1'b1;
                overrun_o            <= rx_if.rx_valid && !rx_if.rx_ready;
                stop_bit_check_error <= !rx_s;
                parity_check_error   <= par_err_q;
              end else begin
                os_cnt <= os_next;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//   Directed bench for uart_rx_core at baud_div=4 (64 clk per bit).
//   The frame driver pushes the expected {byte, parity_err, stop_err} for each
//   frame. The expected values are computed from the frame contents.
//   A per-cycle compare process follows the handshake at the level of
//   "unconsumed byte held or not". It checks every publish against the
//   queue, and it also checks the overrun, valid level and data stability.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int BIT_CLKS = 64;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [16:0] baud_div = 17'd4;
  logic        par_en = 1'b0;
  logic        par_odd = 1'b0;
  logic        stop_err, par_err, overrun, busy;
  logic [2:0]  state;

  always #5 clk = ~clk;

  uart_rx_core_if bus ();

  uart_rx_core dut (
    .clk_i                (clk),
    .rst_n_i              (rst_n),
    .rx_i                 (rx),
    .baud_div_i           (baud_div),
    .parity_en_i          (par_en),
    .parity_odd_i         (par_odd),
    .rx_if                (bus),
    .stop_bit_check_error (stop_err),
    .parity_check_error   (par_err),
    .overrun_o            (overrun),
    .busy_o               (busy),
    .state_o              (state)
  );

  // ---------------- scoreboard state ----------------
  logic [9:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          pub_cnt  = 0;
  int          perr_cnt = 0;
  int          serr_cnt = 0;
  int          ovr_cnt  = 0;
  logic [7:0]  last_data = 8'h00;
  logic [7:0]  last_perr_data = 8'h00;
  logic        rst_seen = 1'b0;
  logic        m_has = 1'b0;
  logic        m_prev_ready = 1'b0;
  logic [7:0]  m_prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) rst_seen <= rst_n;

  // Per-cycle compare against the byte-holding model.
  always @(negedge clk) begin
    logic       hold;
    logic       pub;
    logic [9:0] e;
    if (!rst_seen) begin
      chk("reset_outputs", 32'({bus.rx_data, bus.rx_valid, stop_err, par_err, overrun, busy}), 32'd0);
      m_has = 1'b0;
    end else begin
      hold = m_has && !m_prev_ready;
      pub  = overrun || stop_err || par_err || (bus.rx_valid && !hold);
      if (pub) begin
        pub_cnt++;
        chk("publish_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pub_data", 32'(bus.rx_data), 32'(e[9:2]));
          chk("pub_valid", 32'(bus.rx_valid), 32'd1);
          chk("pub_parity_err", 32'(par_err), 32'(e[1]));
          chk("pub_stop_err", 32'(stop_err), 32'(e[0]));
          chk("pub_overrun", 32'(overrun), 32'(hold));
        end
        if (par_err) begin
          perr_cnt++;
          last_perr_data = bus.rx_data;
        end
        if (stop_err) serr_cnt++;
        if (overrun) ovr_cnt++;
        last_data = bus.rx_data;
        m_has = 1'b1;
      end else begin
        chk("valid_level", 32'(bus.rx_valid), 32'(hold));
        if (hold) chk("data_stable", 32'(bus.rx_data), 32'(m_prev_data));
        m_has = hold;
      end
    end
    m_prev_ready = bus.rx_ready;
    m_prev_data  = bus.rx_data;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_cyc(BIT_CLKS);
  endtask

  // The line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic sbit);
    logic perr;
    perr = pen && (((^d) ^ pbit) != par_odd);
    exp_q.push_back({d, perr, !sbit});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(sbit);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      wait_cyc(1);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic saw_busy;
    bus.rx_ready = 1'b1;
    wait_cyc(3);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Plain 8N1 byte.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_idle("a5_idle");
    chk("a5_pub_count", 32'(pub_cnt), 32'd1);
    chk("a5_data", 32'(last_data), 32'hA5);
    chk("a5_no_errors", 32'(perr_cnt + serr_cnt + ovr_cnt), 32'd0);
    chk("a5_valid_dropped", 32'(bus.rx_valid), 32'd0);

    // Even parity, wrong then right parity bit.
    par_en = 1'b1;
    par_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_idle("parity_idle");
    chk("parity_pub_count", 32'(pub_cnt), 32'd3);
    chk("parity_err_count", 32'(perr_cnt), 32'd1);
    chk("parity_err_data", 32'(last_perr_data), 32'h07);

    // Stop bit 0 followed by a break.
    par_en = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_cyc(BIT_CLKS);
    chk("break_no_retrigger", 32'(busy), 32'd0);
    wait_cyc(2 * BIT_CLKS);
    rx = 1'b1;
    wait_cyc(2 * BIT_CLKS);
    chk("break_stop_err_count", 32'(serr_cnt), 32'd1);
    chk("break_data", 32'(last_data), 32'h3C);
    chk("break_pub_count", 32'(pub_cnt), 32'd4);
    chk("break_busy", 32'(busy), 32'd0);

    // False start: low for 5 ticks (20 clk).
    rx = 1'b0;
    wait_cyc(20);
    chk("false_start_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_cyc(30);
    chk("false_start_idle", 32'(busy), 32'd0);
    chk("false_start_no_pub", 32'(pub_cnt), 32'd4);

    // Overrun with consumer stalled.
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    wait_idle("overrun_idle");
    chk("overrun_count", 32'(ovr_cnt), 32'd1);
    chk("overrun_data", 32'(bus.rx_data), 32'h22);
    chk("overrun_valid_held", 32'(bus.rx_valid), 32'd1);
    bus.rx_ready = 1'b1;
    wait_cyc(2);
    chk("overrun_valid_drop", 32'(bus.rx_valid), 32'd0);

    // Reset in the middle of the data bits.
    rx = 1'b0;
    wait_cyc(BIT_CLKS + 100);
    chk("midframe_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    wait_cyc(1);
    chk("midframe_reset_busy", 32'(busy), 32'd0);
    chk("midframe_reset_state", 32'(state), 32'd0);
    rx = 1'b1;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(10 * BIT_CLKS);
    chk("midframe_no_pub", 32'(pub_cnt), 32'd6);
    chk("midframe_no_err", 32'(perr_cnt + serr_cnt), 32'd2);

    // Receiver disabled while the line toggles.
    baud_div = 17'd0;
    saw_busy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rx = (i % 7) < 3;
      wait_cyc(1);
      if (busy) saw_busy = 1'b1;
    end
    rx = 1'b1;
    wait_cyc(4);
    chk("disabled_never_busy", 32'(saw_busy), 32'd0);
    chk("disabled_no_pub", 32'(pub_cnt), 32'd6);
    baud_div = 17'd4;
    wait_cyc(4);

    // Odd parity after re-enable.
    par_en = 1'b1;
    par_odd = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    wait_idle("odd_idle");
    chk("odd_pub_count", 32'(pub_cnt), 32'd8);
    chk("odd_err_count", 32'(perr_cnt), 32'd2);
    chk("odd_last_data", 32'(last_data), 32'h5A);

    wait_cyc(4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
